// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle sequencer for the E-stage multiply/divide unit.
//
// Accepts one MDU operation per start pulse. The full result is computed and
// held in a pending register at the start edge, then committed to HI/LO after
// MULT_CYCLES or DIV_CYCLES edges. mthi/mtlo write HI/LO directly. The unit
// also raises the D-stage stall request while it is occupied.
//
// Optional build macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10),
// which accumulate into HI/LO. When it is undefined those ops behave as none.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     qualifies op for one cycle
//   op        0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//             7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none
//   rs_data   forwarded rs operand
//   rt_data   forwarded rt operand
//   d_is_mdu  D-stage instruction uses the MDU
//   busy      long operation in progress
//   stall     D-stage stall request (combinational)
//   hi, lo    architectural HI/LO registers
module mdu_seq #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  logic        state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pend_q, pend_d;

  logic        is_mul, is_div, is_long;
  logic [63:0] rs_sx, rt_sx, rs_zx, rt_zx;
  logic [63:0] prod_s, prod_u;
  logic [63:0] mul_res, div_res;
  logic        div_ovf;
  logic [31:0] s_divisor, u_divisor;
  logic signed [31:0] s_quo, s_rem;
  logic [31:0] u_quo, u_rem;

  // Operation class decode.
  always_comb begin
    is_mul = (op == OpMult) || (op == OpMultu);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
`endif
    is_div  = (op == OpDiv) || (op == OpDivu);
    is_long = is_mul || is_div;
  end

  // Low 64 bits of a 64x64 product of sign-extended operands equal the
  // signed 32x32 product.
  assign rs_sx  = {{32{rs_data[31]}}, rs_data};
  assign rt_sx  = {{32{rt_data[31]}}, rt_data};
  assign rs_zx  = {32'h0, rs_data};
  assign rt_zx  = {32'h0, rt_data};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = rs_zx * rt_zx;

  always_comb begin
    mul_res = prod_s;
    case (op)
      OpMult:  mul_res = prod_s;
      OpMultu: mul_res = prod_u;
`ifdef MDU_MADD_EN
      // Accumulator base is HI/LO as seen at the start edge.
      OpMadd:  mul_res = {hi_q, lo_q} + prod_s;
      OpMaddu: mul_res = {hi_q, lo_q} + prod_u;
      OpMsub:  mul_res = {hi_q, lo_q} - prod_s;
      OpMsubu: mul_res = {hi_q, lo_q} - prod_u;
`endif
      default: mul_res = prod_s;
    endcase
  end

  // Divisors are steered to 1 in the special cases so the dividers never see
  // a zero divisor or the signed overflow pair; those results are overridden.
  assign div_ovf   = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
  assign s_divisor = ((rt_data == 32'h0) || div_ovf) ? 32'h1 : rt_data;
  assign u_divisor = (rt_data == 32'h0) ? 32'h1 : rt_data;
  assign s_quo     = $signed(rs_data) / $signed(s_divisor);
  assign s_rem     = $signed(rs_data) % $signed(s_divisor);
  assign u_quo     = rs_data / u_divisor;
  assign u_rem     = rs_data % u_divisor;

  always_comb begin
    if (rt_data == 32'h0) begin
      div_res = {rs_data, 32'hFFFF_FFFF};
    end else if (op == OpDiv) begin
      div_res = div_ovf ? {32'h0, 32'h8000_0000} : {s_rem, s_quo};
    end else begin
      div_res = {u_rem, u_quo};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul) begin
            pend_d  = mul_res;
            cnt_d   = 4'(MULT_CYCLES);
            state_d = StRun;
          end else if (is_div) begin
            pend_d  = div_res;
            cnt_d   = 4'(DIV_CYCLES);
            state_d = StRun;
          end else if (op == OpMthi) begin
            hi_d = rs_data;
          end else if (op == OpMtlo) begin
            lo_d = rs_data;
          end
        end
      end
      StRun: begin
        // start is ignored here; the hazard unit never issues while busy.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      pend_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign stall = d_is_mdu & (busy | (start & is_long));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_is_mdu;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  mdu_seq #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .d_is_mdu(d_is_mdu),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
`ifdef MDU_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  function automatic int m_lat(input logic [3:0] o);
    case (o)
      4'd1, 4'd2:               return 5;
      4'd3, 4'd4:               return 10;
      4'd7, 4'd8, 4'd9, 4'd10:  return MaddEn ? 5 : 0;
      default:                  return 0;
    endcase
  endfunction

  function automatic logic [63:0] m_calc(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    int sa;
    int sb;
    int q;
    int r;
    longint sp;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    ua = a;
    ub = b;
    up = ua * ub;
    case (o)
      4'd1:  return sp;
      4'd2:  return up;
      4'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      4'd4: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd7:  return acc + sp;
      4'd8:  return acc + up;
      4'd9:  return acc - sp;
      4'd10: return acc - up;
      default: return 64'h0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
      m_res  <= 64'h0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (start) begin
      if (m_lat(op) > 0) begin
        m_res  <= m_calc(op, rs_data, rt_data, {m_hi, m_lo});
        m_left <= m_lat(op);
      end else if (op == 4'd5) begin
        m_hi <= rs_data;
      end else if (op == 4'd6) begin
        m_lo <= rs_data;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
    chk("stall", {31'h0, stall},
        {31'h0, d_is_mdu && ((m_left > 0) || (start && (m_lat(op) > 0)))});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; presents one start pulse across the next edge.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("busy_timeout", {31'h0, busy}, 32'h0);
  endtask

  int n;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    op       = 4'd0;
    rs_data  = 32'h0;
    rt_data  = 32'h0;
    d_is_mdu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_op(4'd5, 32'h1234_5678, 32'h0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'h0, busy}, 32'h0);
    do_op(4'd6, 32'h9, 32'h0);
    chk("mtlo_lo", lo, 32'h9);
    chk("mtlo_hi", hi, 32'h1234_5678);

    do_op(4'd1, 32'hFFFF_FFFE, 32'h3);
    wait_idle(n);
    chk("mult_lat", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    do_op(4'd2, 32'hFFFF_FFFE, 32'h3);
    wait_idle(n);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    do_op(4'd3, 32'hFFFF_FFF9, 32'h2);
    wait_idle(n);
    chk("div_lat", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    do_op(4'd3, 32'h7, 32'hFFFF_FFFE);
    wait_idle(n);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'h1);

    do_op(4'd4, 32'h7, 32'h0);
    wait_idle(n);
    chk("divu0_lat", n, 32'd10);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h7);

    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    do_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divu_big_lo", lo, 32'h0);
    chk("divu_big_hi", hi, 32'h8000_0000);

    // Stall with d_is_mdu held.
    d_is_mdu = 1'b1;
    start    = 1'b1;
    op       = 4'd1;
    rs_data  = 32'd6;
    rt_data  = 32'd7;
    #1;
    chk("stall_start", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 4'd0;
    wait_idle(n);
    chk("stall_after", {31'h0, stall}, 32'h0);
    chk("mult42_lo", lo, 32'd42);
    chk("mult42_hi", hi, 32'h0);
    d_is_mdu = 1'b0;

    do_op(4'd1, 32'h1_0000, 32'h1_0000);
    wait_idle(n);
    chk("mult_big_hi", hi, 32'h1);
    chk("mult_big_lo", lo, 32'h0);

    // Start while busy must be ignored.
    do_op(4'd1, 32'd3, 32'd4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_op(4'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'h0);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk("ign_late_lo", lo, 32'd12);

    // Reset in the middle of a divide.
    do_op(4'd5, 32'hAAAA_5555, 32'h0);
    do_op(4'd3, 32'd100, 32'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    chk("arst_late_hi", hi, 32'h0);
    chk("arst_late_lo", lo, 32'h0);
    chk("arst_late_busy", {31'h0, busy}, 32'h0);

    // Accumulate ops.
    do_op(4'd5, 32'h0, 32'h0);
    do_op(4'd6, 32'hFFFF_FFFF, 32'h0);
    do_op(4'd8, 32'h1, 32'h1);
    wait_idle(n);
`ifdef MDU_MADD_EN
    chk("maddu_lat", n, 32'd5);
    chk("maddu_hi", hi, 32'h1);
    chk("maddu_lo", lo, 32'h0);
    do_op(4'd9, 32'h2, 32'h3);
    wait_idle(n);
    chk("msub_hi", hi, 32'h0);
    chk("msub_lo", lo, 32'hFFFF_FFFA);
`else
    chk("maddu_off_lat", n, 32'd0);
    chk("maddu_off_hi", hi, 32'h0);
    chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    // Reserved ops do nothing.
    do_op(4'd12, 32'h5, 32'h5);
    chk("rsvd_busy", {31'h0, busy}, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
